// File: rtl/bsg_front_side_bus_hop_out_multi.sv
// Outbound FSB hop: arbitrates num_in_p valid/yumi channels into one
// valid/ready stream through an els_p-deep FIFO (fixed priority or round-robin).
module bsg_front_side_bus_hop_out_multi #(
  parameter int width_p  = 16,
  parameter int num_in_p = 2,
  parameter int els_p    = 2,
  parameter int rr_p     = 0
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [num_in_p-1:0]           v_i,
  input  logic [num_in_p*width_p-1:0]   data_i,
  output logic [num_in_p-1:0]           yumi_o,
  output logic                          v_o,
  output logic [width_p-1:0]            data_o,
  input  logic                          ready_i,
  output logic [$clog2(els_p+1)-1:0]    count_o
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int sel_w_lp = (num_in_p > 1) ? $clog2(num_in_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] head_q, head_d, tail_q, tail_d;
  logic [sel_w_lp-1:0] rr_ptr_q, rr_ptr_d;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic                full_q, full_d, empty_q, empty_d;

  logic                grant_v;
  logic [sel_w_lp-1:0] grant_idx;
  logic [width_p-1:0]  grant_data;
  logic                enq, deq;

  // Channel index reached by starting at base and stepping off places, wrapping.
  function automatic int rot_idx(input int base, input int off);
    int s;
    s = base + off;
    if (s >= num_in_p) s = s - num_in_p;
    return s;
  endfunction

  // Explicit compare-to-last wrap keeps non-power-of-two depths legal.
  function automatic logic [ptr_w_lp-1:0] wrap_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  // In fixed mode rr_ptr_q never leaves 0, so the scan is plain lowest-index-first.
  always_comb begin
    grant_v    = 1'b0;
    grant_idx  = '0;
    grant_data = '0;
    for (int i = 0; i < num_in_p; i++) begin
      if (!grant_v && v_i[rot_idx(int'(rr_ptr_q), i)]) begin
        grant_v    = 1'b1;
        grant_idx  = sel_w_lp'(rot_idx(int'(rr_ptr_q), i));
        grant_data = data_i[rot_idx(int'(rr_ptr_q), i)*width_p +: width_p];
      end
    end
  end

  always_comb begin
    yumi_o = '0;
    if (grant_v && !full_q && !reset_i) yumi_o[grant_idx] = 1'b1;
  end

  assign enq = |yumi_o;
  assign deq = !empty_q && ready_i;

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    rr_ptr_d = rr_ptr_q;
    count_d  = count_q;
    if (deq) head_d = wrap_inc(head_q);
    if (enq) tail_d = wrap_inc(tail_q);
    if (enq && (rr_p != 0))
      rr_ptr_d = (grant_idx == sel_w_lp'(num_in_p - 1)) ? '0 : grant_idx + 1'b1;
    if (enq && !deq)      count_d = count_q + 1'b1;
    else if (!enq && deq) count_d = count_q - 1'b1;
    full_d  = (count_d == cnt_w_lp'(els_p));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_q   <= '0;
      tail_q   <= '0;
      rr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Payload storage carries no reset; only the control state above does.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[tail_q] <= grant_data;
  end

  assign v_o     = !empty_q;
  assign data_o  = mem_q[head_q];
  assign count_o = count_q;

endmodule

// File: doc/bsg_front_side_bus_hop_out_multi.md
# bsg_front_side_bus_hop_out_multi

Parametrised outbound front-side-bus hop. Arbitrates `num_in_p` valid/yumi input channels, each `width_p` bits, into one `width_p`-bit valid/ready output stream through an `els_p`-deep buffering FIFO. Fixed-priority or round-robin arbitration is chosen at elaboration. It sits between local producers (core, DMA, config) and the outgoing FSB link, replacing the fixed two-channel, two-entry hop.

## Interface
- `width_p`, default 16: payload width per channel and on the output.
- `num_in_p`, default 2: number of input channels; must be ≥1.
- `els_p`, default 2: FIFO depth in entries; must be ≥2.
- `rr_p`, default 0: arbitration mode. 0 = fixed priority, with the lowest index highest. 1 = round-robin.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `v_i`  in  num_in_p  per-channel valid; held until yumi.
- `data_i`  in  num_in_p*width_p  channel i payload at bits [i*width_p +: width_p].
- `yumi_o`  out  num_in_p  one-hot-or-zero accept; combinational from `v_i` and state.
- `v_o`  out  1  output valid; equals FIFO not empty.
- `data_o`  out  width_p  FIFO head entry.
- `ready_i`  in  1  downstream ready; a dequeue occurs when `v_o & ready_i`.
- `count_o`  out  $clog2(els_p+1)  current FIFO occupancy.

## Operation
- **Grant.** When `full` is 0 and at least one `v_i` is set, exactly one `yumi_o` bit is raised. When `full` is 1 or `reset_i` is 1, `yumi_o` is 0.
- **Fixed mode.** The lowest-index valid channel wins. The arbitration pointer stays at 0.
- **Round-robin mode.** `ptr_r` resets to 0. The winner is the first valid index ≥ `ptr_r`, wrapping modulo `num_in_p`.
  - After a grant to channel k, `ptr_r` becomes (k+1) mod `num_in_p`.
  - `ptr_r` is unchanged in any cycle with no grant.
- **Enqueue.** Occurs on any grant. The winning payload is written at `tail_r`, and `tail_r` advances modulo `els_p`.
- **No write bypass when full.** Enqueue is blocked while `full` is 1, even if a dequeue happens in the same cycle.
- **Dequeue.** Occurs when `v_o & ready_i`. `head_r` advances modulo `els_p`.
- **Pointer wrap.** Wrap is explicit compare-to-`els_p`-1, so non-power-of-two depths are legal.
- **Occupancy.** `count_o` is registered:
  - +1 on enqueue only;
  - −1 on dequeue only;
  - unchanged on simultaneous enqueue and dequeue, or on neither.
- **Flags.** `full` = (`count_o` == `els_p`). `empty` = (`count_o` == 0). Both are registered, not recomputed combinationally from pointers.
- **Empty output.** `data_o` is don't-care while `v_o` is 0.
- **Storage reset.** FIFO storage is not reset.
- **Reset.** Asserting `reset_i` at any time immediately forces:
  - `count_o` = 0, `v_o` = 0;
  - `head_r` = `tail_r` = 0, `ptr_r` = 0;
  - `yumi_o` = 0.

  In-flight entries are discarded. After deassertion, operation resumes at the next rising edge.

## Timing
- Reset values: `v_o` = 0, `count_o` = 0, `yumi_o` = 0, `data_o` = X.
- **Latency.** A word granted in cycle t is visible on `v_o`/`data_o` in cycle t+1 at the earliest. There is no combinational input-to-output path.
- **Throughput.** One enqueue and one dequeue per cycle; full rate is sustained when `ready_i` = 1.
- **Full to not-full.** If `count_o` = `els_p` and a dequeue happens in cycle t, grants resume in cycle t+1.
- **Empty with enqueue.** If `count_o` = 0 and an enqueue happens in cycle t, `v_o` = 1 in t+1. The dequeue of that word is possible in t+1.
- **Ordering.** Words leave in grant order. Channel-internal order is preserved.

## Test plan
1. **Asynchronous reset.** Assert `reset_i` mid-cycle with `count_o` = 2 and `v_i` = all ones. Required: `v_o`, `count_o` and `yumi_o` all go to 0 before the next edge. After deassertion, the first output word is post-reset data only.
2. **Fixed priority.** `num_in_p`=2, `rr_p`=0, `ready_i`=1. Ch0 presents 0x1111 and ch1 presents 0x2222, both held until yumi. Required:
   - `yumi_o` = 01 then 10;
   - `data_o` = 0x1111 one cycle after the first grant, then 0x2222.
3. **Full and drain.** `els_p`=2, `ready_i`=0, ch0 streams 0xA0, 0xA1, 0xA2. Required:
   - two grants, then `yumi_o`=0 and `count_o`=2;
   - after `ready_i`=1, outputs 0xA0 then 0xA1;
   - 0xA2 is granted in the cycle after the first dequeue.
4. **Round-robin.** `num_in_p`=3, `rr_p`=1, all channels always valid, `ready_i`=1. Required: grant sequence 0,1,2,0,1,2. Then drop ch1 with `ptr_r`=1: the next grant is ch2.
5. **Starvation check.** `rr_p`=0 with ch0 always valid. Required: ch1 is never granted over 50 cycles. The same stimulus with `rr_p`=1 grants ch1 every other cycle.
6. **Boundaries.**
   - `count_o`=1 with a simultaneous grant and dequeue: `count_o` stays 1 and order is preserved.
   - `els_p`=3: 10 words wrap the pointers correctly, and the output order matches the input order.
